// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: stall-vector layout,
// the four stall encodings, FSM state encoding and common constants.
package pipe_defs;

    localparam int STALL_W      = 6;
    localparam int STALL_PC     = 0;
    localparam int STALL_IF_ID  = 1;
    localparam int STALL_ID_EX  = 2;
    localparam int STALL_EX_MEM = 3;
    localparam int STALL_MEM_WB = 4;
    localparam int STALL_WB     = 5;

    typedef logic [STALL_W-1:0] stall_vec_t;

    // Each encoding freezes the requesting stage and everything upstream of it.
    localparam stall_vec_t STALL_NONE   = 6'b000000;
    localparam stall_vec_t STALL_BY_IF  = 6'b000011;
    localparam stall_vec_t STALL_BY_ID  = 6'b000111;
    localparam stall_vec_t STALL_BY_EX  = 6'b001111;
    localparam stall_vec_t STALL_BY_MEM = 6'b011111;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_REFILL = 2'd2
    } state_e;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Stall-request / exception / hold-vector bundle between the core stages and pipe_ctrl.
interface pipe_ctrl_if;
    import pipe_defs::*;

    logic        stallreq_if;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic        excp_valid;
    logic [31:0] excp_vector;
    stall_vec_t  stall;
    logic        flush;
    logic [31:0] new_pc;

    modport master (
        output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        output excp_valid, excp_vector,
        input  stall, flush, new_pc
    );

    modport slave (
        input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
        input  excp_valid, excp_vector,
        output stall, flush, new_pc
    );

endinterface

// File: rtl/pipe_ctrl_stall_watchdog.sv
// Debug visibility for pipeline stalls: consecutive-stall watchdog with a sticky
// timeout flag, plus a saturating total count of stalled cycles.
module stall_watchdog #(
    parameter int STALL_TIMEOUT = 1024,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_pc,
    input  logic             flush,
    output logic             stall_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int              WD_W     = $clog2(STALL_TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(STALL_TIMEOUT);

    logic [WD_W-1:0]  wd_q, wd_d, wd_inc;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stalled;

    assign stalled = stall_pc && !flush;

    // NOTE: every variable gets a default at the top of the block so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        wd_inc    = wd_q + 1'b1;
        wd_d      = wd_q;
        timeout_d = timeout_q;
        cnt_d     = cnt_q;
        if (!stalled) begin
            wd_d = '0;
        end else begin
            // The run length saturates at the limit; the flag is sticky anyway.
            if (wd_q != WD_LIMIT) wd_d = wd_inc;
            if (wd_inc == WD_LIMIT) timeout_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    assign stall_timeout = timeout_q;
    assign stall_cnt     = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: priority stall encoder, exception flush FSM
// (RUN -> FLUSH -> REFILL) with a one-entry pending exception slot.
module pipe_ctrl
    import pipe_defs::*;
#(
    parameter int REFILL_CYC    = 2,
    parameter int STALL_TIMEOUT = 1024,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    pipe_ctrl_if.slave       bus,
    output logic             stall_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [3:0] REFILL_LOAD = 4'(REFILL_CYC - 1);

    state_e      state_q, state_d;
    logic [3:0]  refill_q, refill_d;
    logic        pend_vld_q, pend_vld_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] new_pc_q, new_pc_d;
    stall_vec_t  stall_enc;
    logic        take_pend;

    always_comb begin : stall_encoder
        if (bus.stallreq_mem)     stall_enc = STALL_BY_MEM;
        else if (bus.stallreq_ex) stall_enc = STALL_BY_EX;
        else if (bus.stallreq_id) stall_enc = STALL_BY_ID;
        else if (bus.stallreq_if) stall_enc = STALL_BY_IF;
        else                      stall_enc = STALL_NONE;
    end

    always_ff @(posedge clk or negedge rst) begin : state_reg
        if (!rst) begin
            state_q    <= ST_RUN;
            refill_q   <= '0;
            pend_vld_q <= 1'b0;
            pend_pc_q  <= ZeroWord;
            new_pc_q   <= ZeroWord;
        end else begin
            state_q    <= state_d;
            refill_q   <= refill_d;
            pend_vld_q <= pend_vld_d;
            pend_pc_q  <= pend_pc_d;
            new_pc_q   <= new_pc_d;
        end
    end

    // Exceptions that arrive while flushing/refilling wait in the slot; oldest wins.
    assign take_pend = bus.excp_valid && !pend_vld_q;

    always_comb begin : next_state
        state_d    = state_q;
        refill_d   = refill_q;
        pend_vld_d = pend_vld_q;
        pend_pc_d  = pend_pc_q;
        new_pc_d   = new_pc_q;
        unique case (state_q)
            ST_RUN: begin
                // The MEM instruction must retire before its exception is taken.
                if (bus.excp_valid && !bus.stallreq_mem) begin
                    state_d  = ST_FLUSH;
                    new_pc_d = bus.excp_vector;
                end
            end
            ST_FLUSH: begin
                state_d  = ST_REFILL;
                refill_d = REFILL_LOAD;
                if (take_pend) begin
                    pend_vld_d = 1'b1;
                    pend_pc_d  = bus.excp_vector;
                end
            end
            ST_REFILL: begin
                if (refill_q == '0) begin
                    // An exception arriving in the last refill cycle fills the
                    // empty slot and is drained on the same edge.
                    if (pend_vld_q) begin
                        state_d    = ST_FLUSH;
                        new_pc_d   = pend_pc_q;
                        pend_vld_d = 1'b0;
                    end else if (bus.excp_valid) begin
                        state_d  = ST_FLUSH;
                        new_pc_d = bus.excp_vector;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    refill_d = refill_q - 1'b1;
                    if (take_pend) begin
                        pend_vld_d = 1'b1;
                        pend_pc_d  = bus.excp_vector;
                    end
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin : outputs
        bus.flush  = (state_q == ST_FLUSH);
        bus.stall  = (state_q == ST_FLUSH) ? STALL_NONE : stall_enc;
        bus.new_pc = new_pc_q;
    end

    stall_watchdog #(
        .STALL_TIMEOUT(STALL_TIMEOUT),
        .CNT_W        (CNT_W)
    ) u_watchdog (
        .clk          (clk),
        .rst          (rst),
        .stall_pc     (bus.stall[STALL_PC]),
        .flush        (bus.flush),
        .stall_timeout(stall_timeout),
        .stall_cnt    (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios with literal expectations
// followed by randomized traffic compared every cycle against a behavioural model.
module tb_pipe_ctrl;

    localparam int R    = 2;
    localparam int TO   = 8;
    localparam int CW   = 5;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst = 1'b0;
    logic          stall_timeout;
    logic [CW-1:0] stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    pipe_ctrl_if bus ();

    pipe_ctrl #(
        .REFILL_CYC   (R),
        .STALL_TIMEOUT(TO),
        .CNT_W        (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .stall_timeout(stall_timeout),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Number of frozen registers grows with the deepest requesting stage.
    function automatic logic [5:0] exp_stall_of(input logic a_if, input logic a_id,
                                                input logic a_ex, input logic a_mem);
        int n;
        n = 0;
        if (a_if)  n = 2;
        if (a_id)  n = 3;
        if (a_ex)  n = 4;
        if (a_mem) n = 5;
        return 6'((1 << n) - 1);
    endfunction

    // Model: m_phase counts cycles since the last flush pulse (0 = flush cycle,
    // 1..R = refill window, >R = normal running).
    int          m_phase  = R + 1;
    logic [31:0] m_pc     = '0;
    logic [31:0] m_pend[$];
    int          m_consec = 0;
    logic        m_to     = 1'b0;
    int          m_cnt    = 0;

    always @(posedge clk or negedge rst) begin : model
        logic        any_req;
        logic        go;
        logic [31:0] nv;
        if (!rst) begin
            m_phase  = R + 1;
            m_pc     = '0;
            m_pend.delete();
            m_consec = 0;
            m_to     = 1'b0;
            m_cnt    = 0;
        end else begin
            any_req = bus.stallreq_if | bus.stallreq_id | bus.stallreq_ex | bus.stallreq_mem;
            if (m_phase != 0 && any_req) begin
                m_consec++;
                if (m_consec >= TO) m_to = 1'b1;
                if (m_cnt < CMAX) m_cnt++;
            end else begin
                m_consec = 0;
            end
            go = 1'b0;
            nv = '0;
            if (m_phase > R) begin
                if (bus.excp_valid && !bus.stallreq_mem) begin
                    go = 1'b1;
                    nv = bus.excp_vector;
                end
            end else if (m_phase == R) begin
                if (m_pend.size() > 0) begin
                    go = 1'b1;
                    nv = m_pend.pop_front();
                end else if (bus.excp_valid) begin
                    go = 1'b1;
                    nv = bus.excp_vector;
                end
            end else if (bus.excp_valid && m_pend.size() == 0) begin
                m_pend.push_back(bus.excp_vector);
            end
            if (go) begin
                m_phase = 0;
                m_pc    = nv;
            end else if (m_phase <= R) begin
                m_phase++;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [5:0] es;
        es = (m_phase == 0) ? 6'b0 :
             exp_stall_of(bus.stallreq_if, bus.stallreq_id, bus.stallreq_ex, bus.stallreq_mem);
        check("model_stall", 64'(bus.stall), 64'(es));
        check("model_flush", 64'(bus.flush), 64'(m_phase == 0));
        if (m_phase == 0) check("model_new_pc", 64'(bus.new_pc), 64'(m_pc));
        check("model_timeout", 64'(stall_timeout), 64'(m_to));
        check("model_stall_cnt", 64'(stall_cnt), 64'(m_cnt));
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_req(input logic a_if, input logic a_id, input logic a_ex, input logic a_mem);
        bus.stallreq_if  = a_if;
        bus.stallreq_id  = a_id;
        bus.stallreq_ex  = a_ex;
        bus.stallreq_mem = a_mem;
    endtask

    initial begin : guard
        #500000;
        $display("FAIL time_limit: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "time limit");
    end

    initial begin : stim
        set_req(0, 0, 0, 0);
        bus.excp_valid  = 1'b0;
        bus.excp_vector = '0;
        repeat (3) next_cycle();
        rst = 1'b1;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            mid();
            check("idle_stall", 64'(bus.stall), 64'h0);
            check("idle_flush", 64'(bus.flush), 64'h0);
            check("idle_cnt", 64'(stall_cnt), 64'h0);
            next_cycle();
        end

        // ex + id together: ex wins
        set_req(0, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            mid();
            check("ex_id_stall", 64'(bus.stall), 64'b001111);
            next_cycle();
        end
        set_req(0, 0, 0, 0);
        mid();
        check("ex_id_drop_stall", 64'(bus.stall), 64'h0);
        check("ex_id_cnt", 64'(stall_cnt), 64'd3);
        next_cycle();

        // Basic exception, flush overrides a stall request in the flush cycle
        bus.excp_valid  = 1'b1;
        bus.excp_vector = 32'h20;
        mid();
        check("excp_pre_flush", 64'(bus.flush), 64'h0);
        next_cycle();
        bus.excp_valid = 1'b0;
        set_req(1, 0, 0, 0);
        mid();
        check("excp_flush", 64'(bus.flush), 64'h1);
        check("excp_new_pc", 64'(bus.new_pc), 64'h20);
        check("excp_flush_stall", 64'(bus.stall), 64'h0);
        next_cycle();
        set_req(0, 0, 0, 0);
        mid();
        check("refill1_flush", 64'(bus.flush), 64'h0);
        next_cycle();
        mid();
        check("refill2_flush", 64'(bus.flush), 64'h0);
        next_cycle();
        bus.excp_valid  = 1'b1;
        bus.excp_vector = 32'h60;
        mid();
        check("run_again_flush", 64'(bus.flush), 64'h0);
        next_cycle();
        bus.excp_valid = 1'b0;
        mid();
        check("run_again_new_pc", 64'(bus.new_pc), 64'h60);
        repeat (3) next_cycle();

        // Exception held off by a MEM wait
        bus.excp_valid  = 1'b1;
        bus.excp_vector = 32'h44;
        set_req(0, 0, 0, 1);
        for (int i = 0; i < 2; i++) begin
            mid();
            check("mem_hold_flush", 64'(bus.flush), 64'h0);
            next_cycle();
        end
        set_req(0, 0, 0, 0);
        mid();
        check("mem_drop_flush", 64'(bus.flush), 64'h0);
        next_cycle();
        bus.excp_valid = 1'b0;
        mid();
        check("mem_late_flush", 64'(bus.flush), 64'h1);
        check("mem_late_new_pc", 64'(bus.new_pc), 64'h44);
        repeat (3) next_cycle();

        // Pending slot: oldest wins
        bus.excp_valid  = 1'b1;
        bus.excp_vector = 32'h300;
        next_cycle();
        bus.excp_valid = 1'b0;
        mid();
        check("pend_first_flush", 64'(bus.flush), 64'h1);
        check("pend_first_pc", 64'(bus.new_pc), 64'h300);
        next_cycle();
        bus.excp_valid  = 1'b1;
        bus.excp_vector = 32'h100;
        mid();
        check("pend_r1_flush", 64'(bus.flush), 64'h0);
        next_cycle();
        bus.excp_vector = 32'h200;
        mid();
        check("pend_r2_flush", 64'(bus.flush), 64'h0);
        next_cycle();
        bus.excp_valid = 1'b0;
        mid();
        check("pend_second_flush", 64'(bus.flush), 64'h1);
        check("pend_second_pc", 64'(bus.new_pc), 64'h100);
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            mid();
            check("pend_dropped_flush", 64'(bus.flush), 64'h0);
        end

        // Reset in the middle of a flush
        next_cycle();
        bus.excp_valid  = 1'b1;
        bus.excp_vector = 32'h500;
        next_cycle();
        bus.excp_valid = 1'b0;
        mid();
        check("rst_pre_flush", 64'(bus.flush), 64'h1);
        #1 rst = 1'b0;
        #1;
        check("rst_flush", 64'(bus.flush), 64'h0);
        check("rst_new_pc", 64'(bus.new_pc), 64'h0);
        check("rst_cnt", 64'(stall_cnt), 64'h0);
        repeat (2) next_cycle();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mid();
            check("post_rst_flush", 64'(bus.flush), 64'h0);
            next_cycle();
        end

        // Watchdog
        set_req(0, 0, 0, 1);
        for (int i = 0; i < TO; i++) begin
            mid();
            check("wd_before", 64'(stall_timeout), 64'h0);
            next_cycle();
        end
        set_req(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            mid();
            check("wd_sticky", 64'(stall_timeout), 64'h1);
            next_cycle();
        end
        rst = 1'b0;
        #1;
        check("wd_rst", 64'(stall_timeout), 64'h0);
        next_cycle();
        rst = 1'b1;

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            next_cycle();
            set_req($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0);
            bus.excp_valid  = ($urandom_range(0, 5) == 0);
            bus.excp_vector = $urandom;
        end
        mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the five-stage core. It turns per-stage stall requests into the per-register hold vector that freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB, including the MEM/WB register that feeds the register-file write port. It also sequences exception flushes: a registered one-cycle flush with redirect PC, then a short refill window. A stall watchdog and a saturating stall-cycle counter provide debug visibility.

## Interface
- REFILL_CYC, 2: cycles spent in REFILL after a flush (1..15)
- STALL_TIMEOUT, 1024: consecutive stalled cycles that set `stall_timeout`
- CNT_W, 32: width of `stall_cnt`
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low (asserted when 0)
- stallreq_if  in  1  fetch waiting on instruction bus
- stallreq_id  in  1  load-use hazard
- stallreq_ex  in  1  multi-cycle EX op busy
- stallreq_mem  in  1  data bus wait
- excp_valid  in  1  exception committed from MEM stage
- excp_vector  in  32  handler address for that exception
- stall  out  6  hold vector: bit0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 WB (reserved, always 0)
- flush  out  1  clear all pipeline registers to NOP, load `new_pc`
- new_pc  out  32  redirect target, valid when `flush`=1
- stall_timeout  out  1  sticky watchdog flag
- stall_cnt  out  CNT_W  saturating count of cycles with stall[0]=1

## Operation
- States: RUN, FLUSH, REFILL. Reset state RUN.
- Stall encoding is combinational with priority mem > ex > id > if:
  - mem → 011111; ex → 001111; id → 000111; if → 000011; none → 000000.
- In FLUSH, `stall` is forced to 000000. In RUN and REFILL it follows the encoding.
- In RUN, `excp_valid` is sampled only when `stallreq_mem`=0. The MEM instruction must complete first. If sampled, the controller latches `excp_vector` into `new_pc` and enters FLUSH.
- FLUSH lasts exactly one cycle with `flush`=1. It then enters REFILL with the refill counter loaded to REFILL_CYC-1.
- REFILL decrements the counter each cycle and goes to RUN after the cycle in which the counter is 0.
- Pending slot (1 entry):
  - `excp_valid` arriving in FLUSH or REFILL is stored in the pending slot if the slot is empty. If the slot is full, the later exception is dropped (oldest wins).
  - On REFILL→RUN with the pending slot full, the controller goes directly to FLUSH using the pending vector and clears the slot.
- Watchdog:
  - The counter increments on each cycle with stall[0]=1 and clears on any cycle with stall[0]=0 or `flush`=1.
  - Reaching STALL_TIMEOUT sets `stall_timeout`. It stays set until reset.
- `stall_cnt` increments on each cycle with stall[0]=1 and saturates at all-ones.

## Timing
- Reset values: stall=0, flush=0, new_pc=0, stall_timeout=0, stall_cnt=0, pending empty, state RUN.
- Stall latency 0: `stall` responds in the same cycle as the request.
- Flush latency 1: `excp_valid` sampled at edge T gives `flush`=1 and `new_pc` valid for the cycle after T, deasserted at T+2.
- Exception and stall requests in the same RUN cycle:
  - that cycle's `stall` still follows the requests;
  - the flush cycle overrides the stall.
- Back-to-back exceptions are spaced by at least 1+REFILL_CYC cycles between flush pulses.
- Reset asserted mid-FLUSH/REFILL: all state returns to reset values immediately (async). No flush is emitted after reset release.

## Structure
- Shared package `pipe_defs`:
  - stall-vector width and bit indices (STALL_PC … STALL_WB);
  - the four stall encodings;
  - state encoding;
  - ZeroWord.
- One natural sub-module, `stall_watchdog`: the consecutive-stall counter, timeout compare, sticky flag and saturating `stall_cnt`.
- The rest is FSM, pending slot and stall encoder in `pipe_ctrl`.

## Test plan
- Reset release with all requests low → stall=000000, flush=0, stall_cnt=0 for 10 cycles.
- stallreq_ex=1 and stallreq_id=1 together for 3 cycles → stall=001111 each cycle, stall_cnt=3. Drop both → stall=000000.
- excp_valid=1 with excp_vector=0x0000_0020 at edge T:
  - flush=1 and new_pc=0x20 for exactly cycle T+1;
  - stall=0 in T+1;
  - RUN resumes after 2 REFILL cycles.
- excp_valid with stallreq_mem=1 → no flush. Drop stallreq_mem while excp_valid is held → flush next cycle.
- Exceptions 0x100 during REFILL and then 0x200 → second flush carries new_pc=0x100; 0x200 is never flushed.
- STALL_TIMEOUT=8 with stallreq_mem held 8 cycles → stall_timeout=1 and stays 1 after the request drops, until rst=0.
